nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder that feeds one four_bit_adder instance a nibble per cycle.
//  It is the stage directly upstream and downstream of four_bit_adder.
//  Operands arrive on a valid/ready input handshake. The carry ripples through a register between nibbles.
//  The WIDTH-bit sum and carry-out leave on a valid/ready output handshake.
// PARAMETERS
//  WIDTH    16  operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4  localparam; number of ADD cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      block can accept an operand bundle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in for the least-significant nibble
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  registered sum
//  out_cout   out  1      registered carry-out of the most-significant nibble
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  - Reset (rst=1 at an edge) forces the following values:
//      state=IDLE, out_valid=0, out_sum=0, out_cout=0, busy=0, nibble idx=0, carry reg=0.
//      in_ready=0 while rst=1.
//  - Reset mid-operation aborts the operation: operands are discarded and no out_valid is produced.
//  - FSM, IDLE:
//      in_ready=1.
//      On in_valid&&in_ready: latch in_a/in_b into op regs, carry<=in_cin, idx<=0, go to ADD.
//  - FSM, ADD:
//      in_ready=0.
//      Adder gets a=op_a[4*idx+:4], b=op_b[4*idx+:4], cin=carry.
//      Each edge: work[4*idx+:4]<=sum, carry<=cout, idx<=idx+1.
//      On the edge with idx==NIBBLES-1: out_sum<={sum,work[lower]}, out_cout<=cout, go to DONE.
//  - FSM, DONE:
//      out_valid=1. out_sum/out_cout are held stable until out_ready=1.
//      On out_valid&&out_ready: go to IDLE the next cycle.
//      No new input is accepted in DONE.
//  - Latency: out_valid rises exactly NIBBLES edges after the accept edge (4 for WIDTH=16).
//  - Throughput: at most one result per NIBBLES+2 cycles.
//  - Input handling: in_a, in_b and in_cin are sampled only on the accept edge.
//      Changes at any other time are ignored.
//  - Output stability: out_sum/out_cout change only on DONE entry and on reset.
//      Between operations they keep the last result.
//  - Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, computed modulo 2^(WIDTH+1).
//  - idx width is $clog2(NIBBLES), minimum 1. idx never wraps past NIBBLES-1.
//  - WIDTH=4 degenerates to a single ADD cycle.
// STRUCTURE
//  - Package nibble_adder_pkg holds:
//      NIBBLE_W=4.
//      typedef enum logic [1:0] {IDLE, ADD, DONE} nsa_state_t.
//  - Exactly one sub-module: one four_bit_adder instance, with a/b/cin driven from the selected nibble.
//      No other arithmetic in this block.
//  - One always_ff for the FSM and datapath registers.
//  - in_ready, out_valid and busy are decoded combinationally from state.
// TESTING (WIDTH=16 unless stated)
//  1. Reset: rst=1 for 2 cycles, then 0 -> out_valid=0, out_sum=0, out_cout=0, busy=0.
//     in_ready=0 during reset, in_ready=1 the cycle after release.
//  2. Basic add: 0x1234+0x4321, cin=0 -> out_sum=0x5555, out_cout=0.
//     out_valid rises 4 edges after accept.
//  3. Full ripple:
//     0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1.
//     0xFFFF+0xFFFF, cin=1 -> out_sum=0xFFFF, out_cout=1.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stay stable.
//     in_ready=0 and in_valid is ignored. After out_ready=1, IDLE and in_ready=1 the next cycle.
//  5. Reset mid-op: rst=1 at idx=2 of 0x0F0F+0x0101 -> no out_valid, IDLE next cycle.
//     A following 0x00FF+0x0001 -> out_sum=0x0100, out_cout=0.
//  6. Operand hold: in_valid held high, in_b toggled during ADD -> result uses the accept-edge values.
//     The second op is accepted only after DONE->IDLE. Also run with WIDTH=4: 0xF+0x1 -> sum 0x0, cout 1, 1-cycle ADD.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nibble_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, ADD, DONE} nsa_state_t;
endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple adder: the only arithmetic in the serial adder.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per cycle through a single four_bit_adder,
// with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Producers keep data stable while valid is high and ready is low.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output nsa_state_t       dbg_state
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t       state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign nib_a = op_a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = op_b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  four_bit_adder u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Work register with the current nibble merged in; on the last nibble this is the full sum.
  always_comb begin
    work_d = work_q;
    work_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ADD) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_q  <= in_a;
            op_b_q  <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          work_q  <= work_d;
          carry_q <= nib_cout;
          if (idx_q == LAST_IDX) begin
            sum_q   <= work_d;
            cout_q  <= nib_cout;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
